ce_reset_gen: RTL and testbench
===============================

CE_RESET_GEN -- requirements
Module: ce_reset_gen

Interface
REQ-001 SHALL have parameter DIV, default 12; system clocks per CPU enable (42.954545 MHz / 12 = 3.579545 MHz).
REQ-002 SHALL have parameter LOCK_HOLD, default 1024; cycles `locked` must stay stable before release.
REQ-003 SHALL have port `clk`, input, 1 bit; the 42.954545 MHz PLL output and the only clock.
REQ-004 SHALL have port `rst`, input, 1 bit; synchronous, active-high reset.
REQ-005 SHALL have port `pll_locked`, input, 1 bit; PLL lock flag, asynchronous to `clk`.
REQ-006 SHALL have port `user_reset`, input, 1 bit; OSD/button reset request, synchronous.
REQ-007 SHALL have port `pause`, input, 1 bit; suppresses CPU enables only.
REQ-008 SHALL have port `sys_reset`, output, 1 bit; core reset, high while not in RUN.
REQ-009 SHALL have port `ce_cpu`, output, 1 bit; one-cycle pulse, rate clk/DIV.
REQ-010 SHALL have port `ce_cpu_n`, output, 1 bit; one-cycle pulse, DIV/2 cycles after `ce_cpu`.
REQ-011 SHALL have port `ce_pix`, output, 1 bit; one-cycle pulse, rate 2*clk/DIV.
REQ-012 SHALL have port `ready`, output, 1 bit; high in RUN.

Function
REQ-013 SHALL pass `pll_locked` through a 2-flop synchronizer; `lock_s` lags the input by 2 cycles.
REQ-014 SHALL implement states WAIT_LOCK, HOLD and RUN.
REQ-015 WAIT_LOCK: when `lock_s`=1, SHALL load the hold counter with 0 and go to HOLD.
REQ-016 HOLD: SHALL increment the hold counter; `lock_s`=0 SHALL go to WAIT_LOCK; count = LOCK_HOLD-1 SHALL go to RUN.
REQ-017 RUN: `lock_s`=0 SHALL go to WAIT_LOCK; `user_reset`=1 SHALL go to HOLD with the hold counter cleared; lock loss SHALL take priority over `user_reset`.
REQ-018 `sys_reset` and `ready` SHALL be registered: `sys_reset` = (state != RUN) and `ready` = (state == RUN), each one cycle after the state register.
REQ-019 SHALL run the divider counter 0..DIV-1 free in every state and wrap from DIV-1 to 0; it SHALL clear to 0 on the WAIT_LOCK->HOLD and RUN->HOLD transitions.
REQ-020 `ce_cpu` SHALL pulse when count==0; `ce_cpu_n` SHALL pulse when count==DIV/2; `ce_pix` SHALL pulse when count==0 or count==DIV/2.
REQ-021 All enable outputs SHALL be registered and SHALL be 0 unless the registered `ready` is 1.
REQ-022 `pause`=1 SHALL force `ce_cpu` and `ce_cpu_n` to 0 without stopping the counter or `ce_pix`.
REQ-023 The first `ce_cpu` after release SHALL be on the first count==0 while `ready`=1, and no partial-period pulse SHALL occur.
REQ-024 DIV SHALL be even and at least 4; the counter width SHALL be $clog2(DIV) and the hold counter width $clog2(LOCK_HOLD).

Reset
REQ-025 `rst`=1 SHALL force state WAIT_LOCK, all counters 0 and synchronizer flops 0, `sys_reset`=1, and `ready`, `ce_cpu`, `ce_cpu_n` and `ce_pix` to 0 on the next edge.
REQ-026 `rst` asserted in any state, including mid-HOLD or RUN, SHALL restart the sequence.

Structure
REQ-027 A shared package SHALL hold the state enum (WAIT_LOCK/HOLD/RUN) and the DIV_DEFAULT and LOCK_HOLD_DEFAULT constants.
REQ-028 One sub-module, `sync2`, SHALL implement the 2-flop synchronizer; everything else SHALL be flat.

Verification (bench: LOCK_HOLD=16, DIV=12)
REQ-029 Release `rst` with `pll_locked`=1 -> `sys_reset` falls at cycle 2+1+16+1 ±1, and the first `ce_cpu` is on the next count==0.
REQ-030 In RUN -> `ce_cpu` every 12 cycles, `ce_cpu_n` offset by 6, `ce_pix` every 6; count 100 `ce_cpu` pulses in 1200 cycles.
REQ-031 Drop `pll_locked` for 1 cycle during HOLD at count 8 -> state returns to WAIT_LOCK and the full 16-cycle hold restarts.
REQ-032 Drop `pll_locked` in RUN -> `sys_reset`=1 within 4 cycles and all enables 0; `user_reset` asserted in the same cycle is ignored.
REQ-033 Pulse `user_reset` for 1 cycle in RUN -> `sys_reset` high for 17 cycles with no PLL involvement.
REQ-034 `pause`=1 for 50 cycles in RUN -> no `ce_cpu`/`ce_cpu_n`, `ce_pix` continues, and after release `ce_cpu` phase is unchanged relative to `ce_pix`.

Source files
------------

// File: rtl/ce_reset_gen_pkg.sv
// ce_reset_gen_pkg
//   Shared definitions for the clock-enable / reset generator:
//   sequencer state encoding and default timing constants.
package ce_reset_gen_pkg;

    // Reset sequencer states
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,   // waiting for synchronized PLL lock
        HOLD      = 2'd1,   // lock seen, waiting for it to stay stable
        RUN       = 2'd2    // core released, enables running
    } state_t;

    // 42.954545 MHz / 12 = 3.579545 MHz CPU clock
    localparam int DIV_DEFAULT       = 12;
    // Cycles lock must remain stable before releasing the core
    localparam int LOCK_HOLD_DEFAULT = 1024;

endpackage

// File: rtl/ce_reset_gen_sync2.sv
// sync2
//   Two-flop synchronizer for a single asynchronous level signal.
//   Ports:
//     clk - destination clock
//     rst - synchronous active-high reset, clears both flops
//     d   - asynchronous input
//     q   - synchronized output, lags d by two clk edges
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ce_reset_gen.sv
// ce_reset_gen
//   Generates the core reset and the CPU / pixel clock enables from the
//   PLL output clock. The core is held in reset until the PLL lock flag
//   has been stable for LOCK_HOLD cycles; a user reset re-runs the hold
//   without involving the PLL. Enables are only produced while released.
//   Parameters:
//     DIV       - clk cycles per CPU enable; must be even and >= 4
//     LOCK_HOLD - cycles lock must be stable before release
//   Ports:
//     clk        - 42.954545 MHz PLL clock (only clock)
//     rst        - synchronous active-high reset
//     pll_locked - PLL lock flag, asynchronous to clk
//     user_reset - OSD/button reset request, synchronous
//     pause      - suppresses CPU enables (pixel enable keeps running)
//     sys_reset  - core reset, high while not in RUN
//     ce_cpu     - CPU enable pulse, every DIV cycles
//     ce_cpu_n   - CPU enable pulse, DIV/2 cycles after ce_cpu
//     ce_pix     - pixel enable pulse, every DIV/2 cycles
//     ready      - high while in RUN
module ce_reset_gen
    import ce_reset_gen_pkg::*;
#(
    parameter int DIV       = DIV_DEFAULT,
    parameter int LOCK_HOLD = LOCK_HOLD_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    input  logic user_reset,
    input  logic pause,
    output logic sys_reset,
    output logic ce_cpu,
    output logic ce_cpu_n,
    output logic ce_pix,
    output logic ready
);

    localparam int CW = $clog2(DIV);
    localparam int HW = $clog2(LOCK_HOLD);

    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LOCK_HOLD - 1);

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [HW-1:0]   hold_cnt;
    logic            lock_s;
    logic            hold_clr, hold_inc, div_clr;
    logic            en_ok;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // Next-state logic. Lock loss always wins over a user reset request.
    always_comb begin
        state_nx = state;
        hold_clr = 1'b0;
        hold_inc = 1'b0;
        div_clr  = 1'b0;
        case (state)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nx = HOLD;
                    hold_clr = 1'b1;
                    div_clr  = 1'b1;
                end
            end
            HOLD: begin
                hold_inc = 1'b1;
                if (!lock_s)
                    state_nx = WAIT_LOCK;
                else if (hold_cnt == HOLD_MAX)
                    state_nx = RUN;
            end
            RUN: begin
                if (!lock_s) begin
                    state_nx = WAIT_LOCK;
                end else if (user_reset) begin
                    state_nx = HOLD;
                    hold_clr = 1'b1;
                    div_clr  = 1'b1;
                end
            end
            default: state_nx = WAIT_LOCK;
        endcase
    end

    // Enables require both the registered ready and a current RUN state,
    // so no enable is ever emitted in the cycle ready drops. Since the
    // divider keeps running through HOLD, the first ce_cpu after release
    // lands on a natural count==0 and is always a full period.
    assign en_ok = ready && (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_LOCK;
            hold_cnt  <= '0;
            cnt       <= '0;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
            ce_cpu    <= 1'b0;
            ce_cpu_n  <= 1'b0;
            ce_pix    <= 1'b0;
        end else begin
            state <= state_nx;

            if (hold_clr)
                hold_cnt <= '0;
            else if (hold_inc)
                hold_cnt <= hold_cnt + 1'b1;

            // Free-running divider, realigned on every entry to HOLD
            if (div_clr || cnt == CNT_MAX)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            sys_reset <= (state != RUN);
            ready     <= (state == RUN);

            ce_cpu   <= en_ok && !pause && (cnt == '0);
            ce_cpu_n <= en_ok && !pause && (cnt == CNT_HALF);
            ce_pix   <= en_ok && ((cnt == '0) || (cnt == CNT_HALF));
        end
    end

endmodule

// File: tb/tb_ce_reset_gen.sv
// tb_ce_reset_gen
//   Directed bench for ce_reset_gen with DIV=12, LOCK_HOLD=16. Cycle
//   numbers are counted in clk edges from the edge after which an input
//   was changed; expected latencies are worked out by hand below.
module tb_ce_reset_gen;

    localparam int DIV = 12;
    localparam int LH  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pll_locked = 1'b0;
    logic user_reset = 1'b0;
    logic pause = 1'b0;
    logic sys_reset, ce_cpu, ce_cpu_n, ce_pix, ready;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;
    int spur   = 0;

    ce_reset_gen #(.DIV(DIV), .LOCK_HOLD(LH)) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .user_reset (user_reset),
        .pause      (pause),
        .sys_reset  (sys_reset),
        .ce_cpu     (ce_cpu),
        .ce_cpu_n   (ce_cpu_n),
        .ce_pix     (ce_pix),
        .ready      (ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Any enable seen while not ready is an error
    always @(negedge clk)
        if (!ready && (ce_cpu || ce_cpu_n || ce_pix)) spur <= spur + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d exp %0d", tag, got, exp);
    endtask

    // Edge number at which sys_reset is first seen low, -1 on timeout
    task automatic wait_fall(output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (!sys_reset) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_ce(output int at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (ce_cpu) begin
                at = cyc;
                break;
            end
        end
    endtask

    int t0, f, c, p, e, d, last_cpu, last_pix;
    int ncpu, ncn, npix, badph, pcpu, pcn, ppix;

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_sys_reset", sys_reset, 1);
        chk("rst_ready", ready, 0);
        chk("rst_ce_cpu", ce_cpu, 0);
        chk("rst_ce_cpu_n", ce_cpu_n, 0);
        chk("rst_ce_pix", ce_pix, 0);

        pll_locked = 1'b1;
        step();
        chk("rst_held_locked", sys_reset, 1);

        // Release: sync 2, WAIT_LOCK->HOLD 1, hold 16, registered output 1
        rst = 1'b0;
        t0 = cyc;
        wait_fall(f);
        chk("release_at", f - t0, 20);
        chk("ready_run", ready, 1);
        // Divider zeroed at HOLD entry (edge 3): count is 5 at edge 20,
        // wraps to 0 at edge 27, registered ce_cpu at edge 28
        wait_ce(c);
        chk("first_ce_cpu", c - t0, 28);

        // Steady-state enable pattern over 1200 cycles
        ncpu = 0; ncn = 0; npix = 0; badph = 0;
        last_cpu = c; last_pix = c;
        for (int i = 0; i < 1200; i++) begin
            step();
            if (ce_cpu) begin
                ncpu++;
                if (cyc - last_cpu != 12) badph++;
                last_cpu = cyc;
            end
            if (ce_cpu_n) begin
                ncn++;
                if (cyc - last_cpu != 6) badph++;
            end
            if (ce_pix) begin
                npix++;
                if (cyc - last_pix != 6) badph++;
                last_pix = cyc;
            end
        end
        chk("run_ce_cpu_cnt", ncpu, 100);
        chk("run_ce_cpu_n_cnt", ncn, 100);
        chk("run_ce_pix_cnt", npix, 200);
        chk("run_phase_err", badph, 0);

        // Pause for 50 cycles starting right after a ce_cpu edge:
        // ce_pix at +6,+12,...,+48 -> 8 pulses
        pause = 1'b1;
        pcpu = 0; pcn = 0; ppix = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (ce_cpu) pcpu++;
            if (ce_cpu_n) pcn++;
            if (ce_pix) ppix++;
        end
        pause = 1'b0;
        chk("pause_ce_cpu", pcpu, 0);
        chk("pause_ce_cpu_n", pcn, 0);
        chk("pause_ce_pix", ppix, 8);
        wait_ce(p);
        chk("pause_phase", (p - c) % 12, 0);
        chk("pause_pix_align", ce_pix, 1);

        // One-cycle user reset: HOLD entered at edge e, RUN at e+16,
        // sys_reset falls at e+17, first ce_cpu at e+25
        user_reset = 1'b1;
        step();
        user_reset = 1'b0;
        e = cyc;
        step();
        chk("ureset_rise", sys_reset, 1);
        wait_fall(f);
        chk("ureset_len", f - e, 17);
        wait_ce(c);
        chk("ureset_first_ce", c - e, 25);

        // One-cycle lock drop in RUN with user_reset sampled on the same
        // edge that sees lock_s low. Lock wins: WAIT_LOCK at d+3, HOLD at
        // d+4, release at d+21 (user_reset winning would give d+20).
        d = cyc;
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        step();
        user_reset = 1'b1;
        step();
        user_reset = 1'b0;
        step();
        chk("lockloss_sys_reset", sys_reset, 1);
        chk("lockloss_ready", ready, 0);
        chk("lockloss_ce_pix", ce_pix, 0);
        wait_fall(f);
        chk("lockloss_release", f - d, 21);

        // Reset mid-RUN, then a lock glitch at hold count 8
        step();
        rst = 1'b1;
        step();
        chk("midrun_rst_sys_reset", sys_reset, 1);
        chk("midrun_rst_ready", ready, 0);
        rst = 1'b0;
        t0 = cyc;
        repeat (9) step();
        // lock_s low is seen by the FSM at edge 12 while hold count is 8
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        wait_fall(f);
        chk("hold_restart", f - t0, 30);

        chk("no_ce_out_of_run", spur, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
